// File: rtl/mcpu6bit_mem_responder_if.sv
// mcpu6bit_mem_responder_if: CPU bus and program-loader signals of the 6-bit CPU memory responder.
//   master : the CPU + loader side (drives cpu_bus, cpu_we_n, ld_en, ld_valid, ld_data)
//   slave  : the memory responder (drives cpu_din, cpu_rst_n, ld_ready, ld_done, io_out)
//   cpu_bus  - {00,addr} while clk=1, accumulator while clk=0
//   cpu_we_n - CPU write enable, active-low
//   cpu_din  - read data to CPU
//   ld_*     - program loader handshake (ld_valid/ld_ready) with enable level and done flag
//   io_out   - memory-mapped output register
interface mcpu6bit_mem_responder_if #(
  parameter int unsigned DW = 6
);
  logic [DW-1:0] cpu_bus;
  logic          cpu_we_n;
  logic [DW-1:0] cpu_din;
  logic          cpu_rst_n;
  logic          ld_en;
  logic          ld_valid;
  logic [DW-1:0] ld_data;
  logic          ld_ready;
  logic          ld_done;
  logic [DW-1:0] io_out;

  modport master (
    output cpu_bus, cpu_we_n, ld_en, ld_valid, ld_data,
    input  cpu_din, cpu_rst_n, ld_ready, ld_done, io_out
  );

  modport slave (
    input  cpu_bus, cpu_we_n, ld_en, ld_valid, ld_data,
    output cpu_din, cpu_rst_n, ld_ready, ld_done, io_out
  );
endinterface

// File: rtl/mcpu6bit_mem_responder.sv
// mcpu6bit_mem_responder: 2**AW x DW RAM behind the clk-multiplexed 6-bit CPU bus,
// with a handshaked program loader that holds the CPU in reset while loading.
// Ports:
//   clk - clock; address latched on negedge, writes and loader FSM on posedge
//   rst - synchronous, active-low reset
//   bus - mcpu6bit_mem_responder_if.slave (cpu_bus, cpu_we_n, cpu_din, cpu_rst_n,
//         ld_en, ld_valid, ld_data, ld_ready, ld_done, io_out)
// Build option: define MCPU6_MEMRESP_IO_EN to mirror every write to the top address
// into io_out; otherwise io_out is tied to 0 and the top address is plain RAM.
module mcpu6bit_mem_responder #(
  parameter int unsigned AW = 4,
  parameter int unsigned DW = 6
) (
  input  logic                     clk,
  input  logic                     rst,
  mcpu6bit_mem_responder_if.slave  bus
);
  localparam int unsigned DEPTH = 2 ** AW;
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } ld_state_t;

  ld_state_t     ld_state, ld_state_nx;
  logic [AW-1:0] ld_ptr, ld_ptr_nx;
  logic [AW-1:0] addr_q;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          ld_ready_q, ld_done_q, cpu_rst_n_q;
  logic [DW-1:0] mem [DEPTH];

  // Address phase ends at the falling edge; capture the address bits there.
  always_ff @(negedge clk) begin
    if (!rst) addr_q <= '0;
    else      addr_q <= bus.cpu_bus[AW-1:0];
  end

  // Read path is combinational so data is settled during the clk-low phase.
  assign bus.cpu_din = mem[addr_q];

  // Loader state register and registered handshake/reset outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      ld_state    <= IDLE;
      ld_ptr      <= '0;
      ld_ready_q  <= 1'b0;
      ld_done_q   <= 1'b0;
      cpu_rst_n_q <= 1'b0;
    end else begin
      ld_state    <= ld_state_nx;
      ld_ptr      <= ld_ptr_nx;
      ld_ready_q  <= (ld_state_nx == LOAD);
      ld_done_q   <= (ld_state_nx == DONE);
      // Drop CPU reset as soon as a load starts; release it one cycle after IDLE resumes.
      cpu_rst_n_q <= (ld_state == IDLE) && (ld_state_nx == IDLE);
    end
  end

  assign bus.ld_ready  = ld_ready_q;
  assign bus.ld_done   = ld_done_q;
  assign bus.cpu_rst_n = cpu_rst_n_q;

  // Next state and write-port selection; CPU writes only in IDLE, so ports never collide.
  always_comb begin
    ld_state_nx = ld_state;
    ld_ptr_nx   = ld_ptr;
    wr_en       = 1'b0;
    wr_addr     = addr_q;
    wr_data     = bus.cpu_bus;
    unique case (ld_state)
      IDLE: begin
        wr_en = !bus.cpu_we_n;
        if (bus.ld_en) begin
          ld_state_nx = LOAD;
          ld_ptr_nx   = '0;
        end
      end
      LOAD: begin
        // A dropped enable aborts before any further word is taken.
        if (!bus.ld_en) begin
          ld_state_nx = IDLE;
        end else if (bus.ld_valid) begin
          wr_en     = 1'b1;
          wr_addr   = ld_ptr;
          wr_data   = bus.ld_data;
          ld_ptr_nx = ld_ptr + AW'(1);
          if (ld_ptr == LAST_ADDR) ld_state_nx = DONE;
        end
      end
      DONE: begin
        if (!bus.ld_en) ld_state_nx = IDLE;
      end
      default: ld_state_nx = IDLE;
    endcase
    if (!rst) wr_en = 1'b0;
  end

  // RAM array: contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

`ifdef MCPU6_MEMRESP_IO_EN
  logic [DW-1:0] io_q;

  // Output register shadows every write to the top address.
  always_ff @(posedge clk) begin
    if (!rst)                                io_q <= '0;
    else if (wr_en && (wr_addr == LAST_ADDR)) io_q <= wr_data;
  end

  assign bus.io_out = io_q;
`else
  assign bus.io_out = '0;
`endif

endmodule

// File: tb/tb_mcpu6bit_mem_responder.sv
// tb_mcpu6bit_mem_responder: directed and randomized stimulus for mcpu6bit_mem_responder,
// checked every cycle against a behavioural model plus literal expectations.
module tb_mcpu6bit_mem_responder;
  logic clk = 1'b0;
  logic rst;

  mcpu6bit_mem_responder_if #(.DW(6)) bif ();

  mcpu6bit_mem_responder #(.AW(4), .DW(6)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif.slave)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  bit chk_on = 1'b0;

  // Behavioural model: mode 0=idle, 1=loading, 2=done.
  int m_mode  = 0;
  int m_ptr   = 0;
  int m_io    = 0;
  int m_rstn  = 0;
  int m_addr  = 0;
  int m_mem   [16];
  bit m_known [16];

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  task automatic mwrite(input int a, input int x);
    m_mem[a]   = x;
    m_known[a] = 1'b1;
`ifdef MCPU6_MEMRESP_IO_EN
    if (a == 15) m_io = x;
`endif
  endtask

  task automatic model_step(input logic r, input logic en, input logic v, input int d,
                            input logic we_n, input int x);
    int old;
    old = m_mode;
    if (!r) begin
      m_mode = 0;
      m_ptr  = 0;
      m_io   = 0;
      m_rstn = 0;
    end else begin
      case (old)
        0: begin
          if (!we_n) mwrite(m_addr, x);
          if (en) begin
            m_mode = 1;
            m_ptr  = 0;
          end
        end
        1: begin
          if (!en) m_mode = 0;
          else if (v) begin
            mwrite(m_ptr, d);
            if (m_ptr == 15) begin
              m_mode = 2;
              m_ptr  = 0;
            end else begin
              m_ptr++;
            end
          end
        end
        default: if (!en) m_mode = 0;
      endcase
      m_rstn = (old == 0 && m_mode == 0) ? 1 : 0;
    end
  endtask

  // One bus cycle, entered and left just after a rising edge.
  task automatic cycle(input logic r, input logic en, input logic v, input logic [5:0] d,
                       input logic [3:0] a, input logic [5:0] x, input logic we_n,
                       output logic [5:0] din_s);
    rst          = r;
    bif.ld_en    = en;
    bif.ld_valid = v;
    bif.ld_data  = d;
    bif.cpu_we_n = we_n;
    bif.cpu_bus  = {2'b00, a};
    @(negedge clk);
    m_addr = r ? int'(a) : 0;
    #1;
    din_s       = bif.cpu_din;
    bif.cpu_bus = x;
    @(posedge clk);
    model_step(r, en, v, int'(d), we_n, int'(x));
    #1;
  endtask

  logic [5:0] ds;

  task automatic idle();
    cycle(1'b1, 1'b0, 1'b0, 6'd0, 4'd0, 6'd0, 1'b1, ds);
  endtask

  task automatic rd(input logic [3:0] a, input logic [5:0] exp, input string nm);
    cycle(1'b1, 1'b0, 1'b0, 6'd0, a, 6'd0, 1'b1, ds);
    chk(nm, 8'(ds), 8'(exp));
  endtask

  task automatic wr(input logic [3:0] a, input logic [5:0] x);
    cycle(1'b1, 1'b0, 1'b0, 6'd0, a, x, 1'b0, ds);
  endtask

  task automatic ld_word(input logic [5:0] d);
    cycle(1'b1, 1'b1, 1'b1, d, 4'd0, 6'd0, 1'b1, ds);
  endtask

  task automatic ld_start();
    cycle(1'b1, 1'b1, 1'b0, 6'd0, 4'd0, 6'd0, 1'b1, ds);
  endtask

  // Per-cycle comparison against the model, in the clk-low phase.
  always @(negedge clk) begin
    #2;
    if (chk_on) begin
      chk("ld_ready",  8'(bif.ld_ready),  8'(m_mode == 1));
      chk("ld_done",   8'(bif.ld_done),   8'(m_mode == 2));
      chk("cpu_rst_n", 8'(bif.cpu_rst_n), 8'(m_rstn));
      chk("io_out",    8'(bif.io_out),    8'(m_io));
      chk("addr_q",    8'(dut.addr_q),    8'(m_addr));
      if (m_known[m_addr]) chk("cpu_din", 8'(bif.cpu_din), 8'(m_mem[m_addr]));
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit en_r;
    foreach (m_known[i]) m_known[i] = 1'b0;
    rst          = 1'b0;
    bif.ld_en    = 1'b0;
    bif.ld_valid = 1'b0;
    bif.ld_data  = '0;
    bif.cpu_we_n = 1'b1;
    bif.cpu_bus  = '0;

    // Reset
    cycle(1'b0, 1'b0, 1'b0, 6'd0, 4'd7, 6'd0, 1'b1, ds);
    chk_on = 1'b1;
    cycle(1'b0, 1'b0, 1'b0, 6'd0, 4'd3, 6'd0, 1'b1, ds);
    chk("rst_cpu_rst_n", 8'(bif.cpu_rst_n), 8'd0);
    chk("rst_ld_ready",  8'(bif.ld_ready),  8'd0);
    chk("rst_ld_done",   8'(bif.ld_done),   8'd0);
    chk("rst_io_out",    8'(bif.io_out),    8'd0);
    chk("rst_addr_q",    8'(dut.addr_q),    8'd0);

    // Full load of 0..15
    idle();
    ld_start();
    chk("load_ready_start", 8'(bif.ld_ready), 8'd1);
    for (int i = 0; i < 16; i++) begin
      ld_word(6'(i));
      if (i < 15) chk("load_ready", 8'(bif.ld_ready), 8'd1);
    end
    chk("load_done",       8'(bif.ld_done),  8'd1);
    chk("load_ready_done", 8'(bif.ld_ready), 8'd0);
    idle();
    chk("idle_cpu_rst_lag", 8'(bif.cpu_rst_n), 8'd0);
    chk("idle_done_clr",    8'(bif.ld_done),   8'd0);
    idle();
    chk("idle_cpu_rst_rel", 8'(bif.cpu_rst_n), 8'd1);

    // Read back the loaded image
    for (int a = 0; a < 16; a++) rd(4'(a), 6'(a), "read_loaded");

    // CPU write and read-back
    wr(4'd9, 6'h2A);
    rd(4'd9, 6'h2A, "cpu_write_9");

    // CPU write attempt while loading is ignored
    ld_start();
    cycle(1'b1, 1'b1, 1'b0, 6'd0, 4'd9, 6'h11, 1'b0, ds);
    idle();
    idle();
    rd(4'd9, 6'h2A, "write_blocked_in_load");

    // Abort after five words
    ld_start();
    for (int i = 0; i < 5; i++) ld_word(6'(8'h20 + i));
    idle();
    chk("abort_ready", 8'(bif.ld_ready), 8'd0);
    rd(4'd0, 6'h20, "abort_word0");
    rd(4'd4, 6'h24, "abort_word4");
    rd(4'd5, 6'h05, "abort_kept5");
    rd(4'd9, 6'h2A, "abort_kept9");

    // Reset in the middle of a load, then restart from address 0
    ld_start();
    for (int i = 0; i < 3; i++) ld_word(6'(8'h30 + i));
    cycle(1'b0, 1'b1, 1'b1, 6'h3F, 4'd0, 6'd0, 1'b1, ds);
    chk("midrst_ptr",   8'(dut.ld_ptr),   8'd0);
    chk("midrst_ready", 8'(bif.ld_ready), 8'd0);
    ld_start();
    ld_word(6'h10);
    ld_word(6'h11);
    idle();
    idle();
    rd(4'd0, 6'h10, "restart_word0");
    rd(4'd1, 6'h11, "restart_word1");
    rd(4'd2, 6'h32, "restart_kept2");
    rd(4'd3, 6'h23, "restart_kept3");

    // Top-address write and io_out
    wr(4'd15, 6'h3F);
`ifdef MCPU6_MEMRESP_IO_EN
    chk("io_out_write", 8'(bif.io_out), 8'h3F);
`else
    chk("io_out_write", 8'(bif.io_out), 8'h00);
`endif
    rd(4'd15, 6'h3F, "read_top");

    // Randomized traffic, checked every cycle by the compare process
    en_r = 1'b0;
    for (int n = 0; n < 600; n++) begin
      logic r;
      if ($urandom_range(0, 29) == 0) en_r = ~en_r;
      r = ($urandom_range(0, 49) != 0);
      cycle(r, en_r, 1'($urandom_range(0, 1)), 6'($urandom), 4'($urandom),
            6'($urandom), 1'($urandom_range(0, 1)), ds);
    end

    chk_on = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
